alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Producer side of the execute ALU interface.
- Accepts 32-bit RV32I instructions from fetch and decodes OP (0110011) and OP-IMM (0010011).
- Reads a 32x32 register file, generates the immediate, and registers op1/op2/imm/opcode/func3/func7/rd into an ID/EX pipeline register with a valid/ready handshake toward execute.
- Also owns the register file write port driven by writeback.

Parameters:
- XLEN, 32, datapath and register width.
- NREGS, 32, register file depth (x0 hardwired to zero).

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  fetch presents instruction
- instr  in  32  instruction word
- instr_ready  out  1  stage can accept instruction
- flush  in  1  discard ID/EX contents and the incoming instruction
- ex_valid  out  1  ID/EX register holds a valid op
- ex_ready  in  1  execute consumes op this cycle
- op1  out  XLEN  rs1 value
- op2  out  XLEN  rs2 value (OP) or imm (OP-IMM)
- imm  out  XLEN  sign-extended immediate
- opcode  out  7  instr[6:0]
- func3  out  3  instr[14:12]
- func7  out  7  see Behaviour
- rd  out  5  destination register
- rd_we  out  1  result must be written back
- illegal_instr  out  1  one-cycle pulse, unsupported opcode accepted
- wb_en  in  1  writeback enable
- wb_rd  in  5  writeback address
- wb_data  in  XLEN  writeback data

Behaviour:
- Reset (rst=1 at edge):
  - ex_valid, illegal_instr, rd_we = 0.
  - op1, op2, imm, opcode, func3, func7, rd = 0.
  - All register file entries = 0.
  - Reset mid-transfer drops the in-flight op.
- instr_ready = !ex_valid || ex_ready. This is combinational and holds during flush.
- Accept = instr_valid && instr_ready. Latency from accept to ex_valid is 1 cycle. Throughput is 1 op/cycle while ex_ready stays high.
- On accept of a supported opcode:
  - ID/EX loads decoded fields and ex_valid=1.
  - op1 = R[instr[19:15]].
  - imm = sign-extend(instr[31:20]) for OP-IMM; imm = 0 for OP.
  - op2 = R[instr[24:20]] for OP; op2 = imm for OP-IMM.
- func7 rules:
  - OP: instr[31:25].
  - OP-IMM with func3 001 or 101: instr[31:25], so SRAI carries 0100000.
  - Other OP-IMM: 0000000, so ADDI is never seen as SUB.
- rd = instr[11:7]. rd_we = 1 iff the op is valid and rd != 0.
- On accept of any other opcode:
  - No issue; ex_valid clears if the current op was consumed.
  - illegal_instr = 1 for exactly the next cycle.
- Hold: ex_valid && !ex_ready keeps all ID/EX outputs stable and instr_ready=0.
- Consume without new accept: ex_valid falls to 0. Data outputs keep their last value; rd_we = 0.
- Flush has priority over everything:
  - Next cycle ex_valid=0 and rd_we=0.
  - An instruction accepted in the flush cycle is discarded, with no illegal pulse.
- Register file:
  - Read of x0 returns 0.
  - wb_en with wb_rd=0 is ignored.
  - Write takes effect at the clock edge; wb is independent of the handshake.
- Same-cycle accept and writeback to the same source register: the read returns the old value unless bypass is enabled (see below).

Optional Feature:
- Macro: ALU_ISSUE_WB_BYPASS_EN.
- Defined: if wb_en && wb_rd != 0 && wb_rd == rs1 (or rs2), the source operand taken at accept is wb_data. For OP-IMM, only rs1 is bypassed.
- Undefined: no bypass; the register file value before the write is used. The bench must check both builds.

Test Plan:
- Reset, then wb x1=10 and x2=20; issue ADD x3,x1,x2 (0x002081B3) with ex_ready=1 -> next cycle ex_valid=1, op1=10, op2=20, func7=0, rd=3, rd_we=1.
- Issue ADDI x4,x1,-1 (0xFFF08213) -> imm=0xFFFFFFFF, op2=0xFFFFFFFF, func7=0, opcode=0x13.
- Issue SRAI x5,x1,3 (0x4030D293) -> func3=101, func7=0100000, op2=0x00000403.
- Backpressure: ex_valid=1 with ex_ready=0 for 3 cycles while instr_valid=1 -> instr_ready=0 and outputs stable; ex_ready=1 -> next instruction accepted the same cycle.
- Illegal/flush: instr=0x00000063 (branch) -> no ex_valid, illegal_instr pulses 1 cycle. Flush asserted with a valid ADD accept -> ex_valid=0 next cycle.
- Same-cycle wb x1=0x55 with accept of ADD rs1=x1 (x1 previously 10) -> op1=0x55 with ALU_ISSUE_WB_BYPASS_EN, op1=10 without. Any write to x0 leaves reads of x0 = 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// RV32I issue stage for OP / OP-IMM: decodes, reads the register file and feeds execute through an ID/EX register.
// Optional macro ALU_ISSUE_WB_BYPASS_EN forwards same-cycle writeback data into the source operands.
module alu_issue_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [31:0]     instr,
    output logic            instr_ready,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2,
    output logic [XLEN-1:0] imm,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal_instr,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data
);

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic [XLEN-1:0] rf_q [NREGS];

    logic            valid_q, valid_d;
    logic            rdWe_q, rdWe_d;
    logic            illegal_q, illegal_d;
    logic [XLEN-1:0] op1_q, op1_d;
    logic [XLEN-1:0] op2_q, op2_d;
    logic [XLEN-1:0] imm_q, imm_d;
    logic [6:0]      opcode_q, opcode_d;
    logic [2:0]      func3_q, func3_d;
    logic [6:0]      func7_q, func7_d;
    logic [4:0]      rd_q, rd_d;

    logic [4:0]      rs1Addr, rs2Addr, rdAddr;
    logic [6:0]      opc;
    logic [2:0]      f3;
    logic            isOp, isOpImm, accept;
    logic [XLEN-1:0] rs1Val, rs2Val, immExt;
    logic [6:0]      f7;

    assign instr_ready = !valid_q || ex_ready;
    assign accept      = instr_valid && instr_ready;

    assign opc     = instr[6:0];
    assign rdAddr  = instr[11:7];
    assign f3      = instr[14:12];
    assign rs1Addr = instr[19:15];
    assign rs2Addr = instr[24:20];
    assign isOp    = (opc == OPC_OP);
    assign isOpImm = (opc == OPC_OPIMM);

    // Operand fetch; x0 always reads as zero, even while it is being "written"
    always_comb begin
        rs1Val = (rs1Addr == 5'd0) ? '0 : rf_q[rs1Addr];
        rs2Val = (rs2Addr == 5'd0) ? '0 : rf_q[rs2Addr];
`ifdef ALU_ISSUE_WB_BYPASS_EN
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1Addr)) rs1Val = wb_data;
        if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2Addr)) rs2Val = wb_data;
`endif
    end

    // Shift-immediate ops keep funct7 so SRAI is distinguishable; other OP-IMM zero it
    always_comb begin
        immExt = isOpImm ? {{(XLEN-12){instr[31]}}, instr[31:20]} : '0;
        f7     = '0;
        if (isOp || (isOpImm && (f3 == 3'b001 || f3 == 3'b101))) f7 = instr[31:25];
    end

    always_comb begin
        valid_d   = valid_q;
        rdWe_d    = rdWe_q;
        illegal_d = 1'b0;
        op1_d     = op1_q;
        op2_d     = op2_q;
        imm_d     = imm_q;
        opcode_d  = opcode_q;
        func3_d   = func3_q;
        func7_d   = func7_q;
        rd_d      = rd_q;
        if (flush) begin
            valid_d = 1'b0;
            rdWe_d  = 1'b0;
        end else if (accept && (isOp || isOpImm)) begin
            valid_d  = 1'b1;
            rdWe_d   = (rdAddr != 5'd0);
            op1_d    = rs1Val;
            op2_d    = isOp ? rs2Val : immExt;
            imm_d    = immExt;
            opcode_d = opc;
            func3_d  = f3;
            func7_d  = f7;
            rd_d     = rdAddr;
        end else begin
            illegal_d = accept;
            if (ex_ready) begin
                valid_d = 1'b0;
                rdWe_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            rdWe_q    <= 1'b0;
            illegal_q <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            opcode_q  <= '0;
            func3_q   <= '0;
            func7_q   <= '0;
            rd_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            rdWe_q    <= rdWe_d;
            illegal_q <= illegal_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            imm_q     <= imm_d;
            opcode_q  <= opcode_d;
            func3_q   <= func3_d;
            func7_q   <= func7_d;
            rd_q      <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_en && (wb_rd != 5'd0)) begin
            rf_q[wb_rd] <= wb_data;
        end
    end

    assign ex_valid      = valid_q;
    assign rd_we         = rdWe_q;
    assign illegal_instr = illegal_q;
    assign op1           = op1_q;
    assign op2           = op2_q;
    assign imm           = imm_q;
    assign opcode        = opcode_q;
    assign func3         = func3_q;
    assign func7         = func7_q;
    assign rd            = rd_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage; expectations follow ALU_ISSUE_WB_BYPASS_EN when it is defined.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        flush;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] op1, op2, imm;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal_instr;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_issue_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr(instr), .instr_ready(instr_ready),
        .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .op1(op1), .op2(op2), .imm(imm),
        .opcode(opcode), .func3(func3), .func7(func7),
        .rd(rd), .rd_we(rd_we), .illegal_instr(illegal_instr),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy, input logic fl);
        instr_valid = v;
        instr       = ins;
        ex_ready    = rdy;
        flush       = fl;
    endtask

    logic [31:0] expBypass;

    initial begin
        rst = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        tick(); tick();
        rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("rst_rd_we", {31'd0, rd_we}, 32'd0);
        checkOutput("rst_illegal", {31'd0, illegal_instr}, 32'd0);
        checkOutput("rst_op1", op1, 32'd0);
        checkOutput("rst_opcode", {25'd0, opcode}, 32'd0);
        checkOutput("rst_instr_ready", {31'd0, instr_ready}, 32'd1);

        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'd10; tick();
        wb_rd = 5'd2; wb_data = 32'd20; tick();
        wb_en = 1'b0;

        $display("[TB] ADD x3,x1,x2");
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0); tick();
        checkOutput("add_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("add_op1", op1, 32'd10);
        checkOutput("add_op2", op2, 32'd20);
        checkOutput("add_imm", imm, 32'd0);
        checkOutput("add_func7", {25'd0, func7}, 32'd0);
        checkOutput("add_rd", {27'd0, rd}, 32'd3);
        checkOutput("add_rd_we", {31'd0, rd_we}, 32'd1);
        checkOutput("add_opcode", {25'd0, opcode}, 32'h33);

        $display("[TB] ADDI x4,x1,-1");
        applyStimulus(1'b1, 32'hFFF08213, 1'b1, 1'b0); tick();
        checkOutput("addi_imm", imm, 32'hFFFFFFFF);
        checkOutput("addi_op2", op2, 32'hFFFFFFFF);
        checkOutput("addi_op1", op1, 32'd10);
        checkOutput("addi_func7", {25'd0, func7}, 32'd0);
        checkOutput("addi_opcode", {25'd0, opcode}, 32'h13);
        checkOutput("addi_rd", {27'd0, rd}, 32'd4);

        $display("[TB] SRAI x5,x1,3");
        applyStimulus(1'b1, 32'h4030D293, 1'b1, 1'b0); tick();
        checkOutput("srai_func3", {29'd0, func3}, 32'd5);
        checkOutput("srai_func7", {25'd0, func7}, 32'h20);
        checkOutput("srai_op2", op2, 32'h403);
        checkOutput("srai_rd", {27'd0, rd}, 32'd5);

        $display("[TB] backpressure");
        applyStimulus(1'b1, 32'h00110333, 1'b0, 1'b0); #1;
        checkOutput("bp_ready_low", {31'd0, instr_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("bp_valid", {31'd0, ex_valid}, 32'd1);
            checkOutput("bp_rd", {27'd0, rd}, 32'd5);
            checkOutput("bp_op2", op2, 32'h403);
            checkOutput("bp_func7", {25'd0, func7}, 32'h20);
            checkOutput("bp_ready", {31'd0, instr_ready}, 32'd0);
        end
        ex_ready = 1'b1; #1;
        checkOutput("bp_release_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        checkOutput("bp_next_rd", {27'd0, rd}, 32'd6);
        checkOutput("bp_next_op1", op1, 32'd20);
        checkOutput("bp_next_op2", op2, 32'd10);
        checkOutput("bp_next_valid", {31'd0, ex_valid}, 32'd1);

        $display("[TB] illegal branch");
        applyStimulus(1'b1, 32'h00000063, 1'b1, 1'b0); tick();
        checkOutput("ill_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("ill_pulse", {31'd0, illegal_instr}, 32'd1);
        checkOutput("ill_rd_we", {31'd0, rd_we}, 32'd0);
        checkOutput("ill_rd_hold", {27'd0, rd}, 32'd6);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();
        checkOutput("ill_pulse_end", {31'd0, illegal_instr}, 32'd0);

        $display("[TB] flush");
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b1); #1;
        checkOutput("fl_ready", {31'd0, instr_ready}, 32'd1);
        tick();
        checkOutput("fl_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("fl_rd_we", {31'd0, rd_we}, 32'd0);
        applyStimulus(1'b1, 32'h00000063, 1'b1, 1'b1); tick();
        checkOutput("fl_no_illegal", {31'd0, illegal_instr}, 32'd0);
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0); tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1); tick();
        checkOutput("fl_held_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("fl_held_rd_we", {31'd0, rd_we}, 32'd0);

        $display("[TB] same-cycle writeback");
`ifdef ALU_ISSUE_WB_BYPASS_EN
        expBypass = 32'h55;
`else
        expBypass = 32'd10;
`endif
        wb_en = 1'b1; wb_rd = 5'd1; wb_data = 32'h55;
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0); tick();
        wb_en = 1'b0;
        checkOutput("byp_op1", op1, expBypass);
        checkOutput("byp_op2", op2, 32'd20);
        tick();
        checkOutput("byp_after_op1", op1, 32'h55);

        $display("[TB] x0 writes");
        wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEAD;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();
        applyStimulus(1'b1, 32'h000003B3, 1'b1, 1'b0); tick();
        wb_en = 1'b0;
        checkOutput("x0_op1", op1, 32'd0);
        checkOutput("x0_op2", op2, 32'd0);
        checkOutput("x0_rd", {27'd0, rd}, 32'd7);
        applyStimulus(1'b1, 32'h00508013, 1'b1, 1'b0); tick();
        checkOutput("rd0_valid", {31'd0, ex_valid}, 32'd1);
        checkOutput("rd0_rd_we", {31'd0, rd_we}, 32'd0);
        checkOutput("rd0_op2", op2, 32'd5);
        checkOutput("rd0_op1", op1, 32'h55);

        $display("[TB] reset mid-transfer");
        applyStimulus(1'b1, 32'h002081B3, 1'b0, 1'b0);
        rst = 1'b1; tick();
        rst = 1'b0;
        checkOutput("mid_rst_valid", {31'd0, ex_valid}, 32'd0);
        checkOutput("mid_rst_op1", op1, 32'd0);
        checkOutput("mid_rst_rd", {27'd0, rd}, 32'd0);
        applyStimulus(1'b1, 32'h002081B3, 1'b1, 1'b0); tick();
        checkOutput("rf_cleared_op1", op1, 32'd0);
        checkOutput("rf_cleared_op2", op2, 32'd0);
        checkOutput("rf_cleared_valid", {31'd0, ex_valid}, 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0); tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
